// File: rtl/cond_select_pkg.sv
// ---------------------------------------------------------------------------
// cond_select_pkg
// Shared definitions for the branch-condition evaluator:
//   - FLAG_* : bit positions of the ALU status flags in the default 4-flag set
//   - buf_state_e : state of the one-entry result buffer
//   - sel_in_range : true when a flag index addresses an existing flag
// Optional feature macro (used by cond_select_unit): COND_SELECT_STATS_EN
// ---------------------------------------------------------------------------
package cond_select_pkg;

    localparam int FLAG_OR    = 0;
    localparam int FLAG_GT    = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_NZERO = 3;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // The select is widened to 32 bits by the caller so that selects wider
    // than the flag vector (e.g. 3-bit select over 5 flags) compare cleanly.
    function automatic logic sel_in_range(input logic [31:0] sel, input int nflag);
        return (sel < $unsigned(nflag));
    endfunction

endpackage

// File: rtl/cond_result_buf.sv
// ---------------------------------------------------------------------------
// cond_result_buf
// One-entry valid/ready output register holding {take, err}.
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   load_i         : store take_i/err_i (only asserted when in_ready_o=1)
//   take_i, err_i  : result to store
//   res_ready_i    : consumer accepts the held result
//   res_valid_o    : a result is held
//   res_take_o     : held condition result
//   res_err_o      : held out-of-range flag
//   in_ready_o     : a new result can be loaded this cycle
// ---------------------------------------------------------------------------
module cond_result_buf
    import cond_select_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic take_i,
    input  logic err_i,
    input  logic res_ready_i,
    output logic res_valid_o,
    output logic res_take_o,
    output logic res_err_o,
    output logic in_ready_o
);

    buf_state_e state_q;
    logic       take_q;
    logic       err_q;

    // Buffer state machine and held result; data only changes on a load so it
    // stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BUF_EMPTY;
            take_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (load_i) begin
                        state_q <= BUF_FULL;
                        take_q  <= take_i;
                        err_q   <= err_i;
                    end else begin
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (res_ready_i && load_i) begin
                        // old result leaves, new one lands on the same edge
                        state_q <= BUF_FULL;
                        take_q  <= take_i;
                        err_q   <= err_i;
                    end else if (res_ready_i) begin
                        state_q <= BUF_EMPTY;
                    end else begin
                        state_q <= BUF_FULL;
                    end
                end
                default: begin
                    state_q <= BUF_EMPTY;
                    take_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; res_ready feeds only the ready path, never the data.
    always_comb begin
        res_valid_o = (state_q == BUF_FULL);
        res_take_o  = take_q;
        res_err_o   = err_q;
        in_ready_o  = reset && ((state_q == BUF_EMPTY) || res_ready_i);
    end

endmodule

// File: rtl/cond_select_unit.sv
// ---------------------------------------------------------------------------
// cond_select_unit
// Branch-condition evaluator: stores ALU flags, selects one (optionally
// inverted) on request and returns it through a one-entry valid/ready buffer.
// Optional feature macro: COND_SELECT_STATS_EN (adds stat_taken/stat_total).
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   flag_we, flag_in      : flag register write
//   eval_valid/eval_ready : request handshake; eval_sel, eval_inv payload
//   res_valid/res_ready   : result handshake; res_take, res_err payload
//   flags_q               : current flag register
//   stat_taken/stat_total : saturating consumed-result counters (macro only)
// ---------------------------------------------------------------------------
module cond_select_unit
    import cond_select_pkg::*;
#(
    parameter int NFLAG = 4,
    parameter int SELW  = $clog2(NFLAG)
`ifdef COND_SELECT_STATS_EN
    ,
    parameter int CNTW  = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_we,
    input  logic [NFLAG-1:0] flag_in,
    input  logic             eval_valid,
    output logic             eval_ready,
    input  logic [SELW-1:0]  eval_sel,
    input  logic             eval_inv,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_take,
    output logic             res_err,
    output logic [NFLAG-1:0] flags_q
`ifdef COND_SELECT_STATS_EN
    ,
    output logic [CNTW-1:0]  stat_taken,
    output logic [CNTW-1:0]  stat_total
`endif
);

    logic [NFLAG-1:0] src_s;
    logic [31:0]      sel_ext_s;
    logic             in_range_s;
    logic             sel_bit_s;
    logic             take_s;
    logic             err_s;
    logic             accept_s;

    // Flag register: loads on flag_we, otherwise holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= {NFLAG{1'b0}};
        end else if (flag_we) begin
            flags_q <= flag_in;
        end else begin
            flags_q <= flags_q;
        end
    end

    // Select/invert: a flag write in the same cycle is forwarded so the
    // evaluation sees the flags being written, not the stale register.
    always_comb begin
        src_s      = flag_we ? flag_in : flags_q;
        sel_ext_s  = {{(32-SELW){1'b0}}, eval_sel};
        in_range_s = sel_in_range(sel_ext_s, NFLAG);
        sel_bit_s  = 1'b0;
        // explicit mux avoids indexing past the flag vector for wide selects
        for (int i = 0; i < NFLAG; i++) begin
            if (sel_ext_s == 32'(i)) begin
                sel_bit_s = src_s[i];
            end else begin
                sel_bit_s = sel_bit_s;
            end
        end
        take_s   = in_range_s ? (sel_bit_s ^ eval_inv) : 1'b0;
        err_s    = !in_range_s;
        accept_s = eval_valid && eval_ready;
    end

    cond_result_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .load_i      (accept_s),
        .take_i      (take_s),
        .err_i       (err_s),
        .res_ready_i (res_ready),
        .res_valid_o (res_valid),
        .res_take_o  (res_take),
        .res_err_o   (res_err),
        .in_ready_o  (eval_ready)
    );

`ifdef COND_SELECT_STATS_EN
    logic [CNTW-1:0] taken_q;
    logic [CNTW-1:0] total_q;
    logic [CNTW-1:0] taken_d;
    logic [CNTW-1:0] total_d;
    logic            consume_s;

    // Next-state for the saturating counters; error results count in total only.
    always_comb begin
        consume_s = res_valid && res_ready;
        taken_d   = taken_q;
        total_d   = total_q;
        if (consume_s) begin
            if (total_q != {CNTW{1'b1}}) begin
                total_d = total_q + {{(CNTW-1){1'b0}}, 1'b1};
            end else begin
                total_d = total_q;
            end
            if (res_take && !res_err && (taken_q != {CNTW{1'b1}})) begin
                taken_d = taken_q + {{(CNTW-1){1'b0}}, 1'b1};
            end else begin
                taken_d = taken_q;
            end
        end else begin
            taken_d = taken_q;
            total_d = total_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            taken_q <= {CNTW{1'b0}};
            total_q <= {CNTW{1'b0}};
        end else begin
            taken_q <= taken_d;
            total_q <= total_d;
        end
    end

    assign stat_taken = taken_q;
    assign stat_total = total_q;
`endif

endmodule

// File: tb/tb_cond_select_unit.sv
module tb_cond_select_unit;
    import cond_select_pkg::*;

    localparam int TB_CNTW = 2;
    localparam int SATMAX  = (1 << TB_CNTW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main instance, 4 flags
    logic       flag_we, eval_valid, eval_inv, res_ready;
    logic [3:0] flag_in;
    logic [1:0] eval_sel;
    logic       eval_ready, res_valid, res_take, res_err;
    logic [3:0] flags_q;

    // second instance, 5 flags with a 3-bit select (out-of-range possible)
    logic       flag_we5, eval_valid5, eval_inv5, res_ready5;
    logic [4:0] flag_in5;
    logic [2:0] eval_sel5;
    logic       eval_ready5, res_valid5, res_take5, res_err5;
    logic [4:0] flags_q5;

`ifdef COND_SELECT_STATS_EN
    logic [TB_CNTW-1:0] stat_taken, stat_total;
    logic [15:0]        stat_taken5, stat_total5;
`endif

    cond_select_unit #(
        .NFLAG(4), .SELW(2)
`ifdef COND_SELECT_STATS_EN
        , .CNTW(TB_CNTW)
`endif
    ) dut (
        .clk(clk), .reset(reset), .flag_we(flag_we), .flag_in(flag_in),
        .eval_valid(eval_valid), .eval_ready(eval_ready), .eval_sel(eval_sel),
        .eval_inv(eval_inv), .res_valid(res_valid), .res_ready(res_ready),
        .res_take(res_take), .res_err(res_err), .flags_q(flags_q)
`ifdef COND_SELECT_STATS_EN
        , .stat_taken(stat_taken), .stat_total(stat_total)
`endif
    );

    cond_select_unit #(
        .NFLAG(5), .SELW(3)
    ) dut5 (
        .clk(clk), .reset(reset), .flag_we(flag_we5), .flag_in(flag_in5),
        .eval_valid(eval_valid5), .eval_ready(eval_ready5), .eval_sel(eval_sel5),
        .eval_inv(eval_inv5), .res_valid(res_valid5), .res_ready(res_ready5),
        .res_take(res_take5), .res_err(res_err5), .flags_q(flags_q5)
`ifdef COND_SELECT_STATS_EN
        , .stat_taken(stat_taken5), .stat_total(stat_total5)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the main instance ----------------
    logic [1:0] mq[$];      // held results, {take, err}; at most one entry
    logic [3:0] mflags;
    logic       m_zero;     // data outputs must read 0 (nothing loaded since reset)
    int         mtot, mtak;
    bit         started = 1'b0;

    always @(posedge clk) begin
        logic [3:0] src;
        logic [1:0] item;
        logic       t, acc;
        started = 1'b1;
        if (!reset) begin
            mflags = 4'd0; mq.delete(); m_zero = 1'b1; mtot = 0; mtak = 0;
        end else begin
            acc = eval_valid && (mq.size() == 0 || res_ready);
            if (mq.size() != 0 && res_ready) begin
                item = mq.pop_front();
                if (mtot < SATMAX) mtot++;
                if (item[1] && mtak < SATMAX) mtak++;
            end
            if (acc) begin
                src = flag_we ? flag_in : mflags;
                t   = src[eval_sel] ^ eval_inv;   // every 2-bit select is in range
                mq.push_back({t, 1'b0});
                m_zero = 1'b0;
            end
            if (flag_we) mflags = flag_in;
        end
    end

    // Compare process: main instance against the model, every cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("eval_ready", eval_ready, reset && (mq.size() == 0 || res_ready));
            chk("res_valid", res_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("res_take", res_take, mq[0][1]);
                chk("res_err", res_err, mq[0][0]);
            end else if (m_zero) begin
                chk("res_take_rst", res_take, 1'b0);
                chk("res_err_rst", res_err, 1'b0);
            end
            chk("flags_q", flags_q, mflags);
`ifdef COND_SELECT_STATS_EN
            chk("stat_total", stat_total, mtot);
            chk("stat_taken", stat_taken, mtak);
`endif
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_main;
        flag_we = 1'b0; eval_valid = 1'b0; eval_sel = 2'd0; eval_inv = 1'b0;
    endtask

    initial begin
        reset = 1'b0; res_ready = 1'b1; flag_in = 4'd0; idle_main();
        flag_we5 = 1'b0; flag_in5 = 5'd0; eval_valid5 = 1'b0; eval_sel5 = 3'd0;
        eval_inv5 = 1'b0; res_ready5 = 1'b0;

        // reset held for two edges
        step(); step();
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_ready", eval_ready, 1'b0);
        chk("rst_flags", flags_q, 4'd0);
        chk("rst_valid5", res_valid5, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", eval_ready, 1'b1);

        // basic select
        step(); flag_we = 1'b1; flag_in = 4'b0100;
        step(); flag_we = 1'b0; eval_valid = 1'b1; eval_sel = FLAG_ZERO[1:0]; eval_inv = 1'b0;
        step(); idle_main();
        @(negedge clk);
        chk("basic_valid", res_valid, 1'b1);
        chk("basic_take_zero", res_take, 1'b1);
        step(); eval_valid = 1'b1; eval_sel = FLAG_GT[1:0]; eval_inv = 1'b1;
        step(); idle_main();
        @(negedge clk);
        chk("basic_take_gt_inv", res_take, 1'b1);

        // forwarding
        step(); flag_we = 1'b1; flag_in = 4'b0000;
        step(); flag_we = 1'b1; flag_in = 4'b1000;
        eval_valid = 1'b1; eval_sel = FLAG_NZERO[1:0]; eval_inv = 1'b0;
        step(); idle_main();
        @(negedge clk);
        chk("fwd_take", res_take, 1'b1);
        chk("fwd_flags", flags_q, 4'b1000);

        // backpressure: first request held, second stalled
        step(); res_ready = 1'b0; eval_valid = 1'b1; eval_sel = FLAG_NZERO[1:0];
        step(); eval_sel = FLAG_OR[1:0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_take_hold", res_take, 1'b1);
            chk("bp_ready_low", eval_ready, 1'b0);
            if (k < 2) step();
        end
        step(); res_ready = 1'b1;
        #1;
        chk("bp_ready_comb", eval_ready, 1'b1);
        step(); idle_main();
        @(negedge clk);
        chk("bp_second_valid", res_valid, 1'b1);
        chk("bp_second_take", res_take, 1'b0);
        step();
        @(negedge clk);
        chk("bp_drained", res_valid, 1'b0);

        // directed pseudo-random traffic, checked by the model
        for (int k = 0; k < 60; k++) begin
            step();
            flag_we    = ($urandom_range(0, 3) == 0);
            flag_in    = 4'($urandom_range(0, 15));
            eval_valid = 1'($urandom_range(0, 1));
            eval_sel   = 2'($urandom_range(0, 3));
            eval_inv   = 1'($urandom_range(0, 1));
            res_ready  = 1'($urandom_range(0, 1));
        end
        step(); idle_main(); res_ready = 1'b1;
        step(); step();

        // out-of-range on the 5-flag instance
        flag_we5 = 1'b1; flag_in5 = 5'b10101;
        step(); flag_we5 = 1'b0; eval_valid5 = 1'b1; eval_sel5 = 3'd7; eval_inv5 = 1'b1;
        step(); eval_valid5 = 1'b0;
        @(negedge clk);
        chk("oor_valid", res_valid5, 1'b1);
        chk("oor_err", res_err5, 1'b1);
        chk("oor_take", res_take5, 1'b0);
        chk("oor_ready_low", eval_ready5, 1'b0);
        step(); res_ready5 = 1'b1;
        #1;
        chk("oor_ready", eval_ready5, 1'b1);
        eval_valid5 = 1'b1; eval_sel5 = 3'd4; eval_inv5 = 1'b0;
        step(); eval_valid5 = 1'b0;
        @(negedge clk);
        chk("sel4_take", res_take5, 1'b1);
        chk("sel4_err", res_err5, 1'b0);
        chk("flags5", flags_q5, 5'b10101);
        step();
        @(negedge clk);
        chk("oor_drained", res_valid5, 1'b0);

        // reset while a result is held
        step(); res_ready = 1'b0; eval_valid = 1'b1; eval_sel = 2'd3;
        step(); idle_main(); reset = 1'b0;
        step(); reset = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        chk("midrst_valid", res_valid, 1'b0);
        chk("midrst_flags", flags_q, 4'd0);

`ifdef COND_SELECT_STATS_EN
        // statistics: five consumed results, four taken, saturating at 3
        step(); flag_we = 1'b1; flag_in = 4'b1111; eval_valid = 1'b1;
        eval_sel = 2'd0; eval_inv = 1'b0;
        step(); flag_we = 1'b0; eval_sel = 2'd1;
        step(); eval_sel = 2'd2;
        step(); eval_sel = 2'd3;
        step(); eval_sel = 2'd0; eval_inv = 1'b1;
        step(); idle_main();
        step();
        @(negedge clk);
        chk("stat_total_sat", stat_total, 2'd3);
        chk("stat_taken_sat", stat_taken, 2'd3);
        step(); reset = 1'b0;
        step(); reset = 1'b1;
        @(negedge clk);
        chk("stat_total_rst", stat_total, 2'd0);
        chk("stat_taken_rst", stat_taken, 2'd0);
`endif

        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
